// File: rtl/bottle_fill_ctrl.sv
// Pill dispensing line sequencer: bottle request, gated BCD pill counting,
// timed bottle swap and batch completion, with registered status outputs.
module bottle_fill_ctrl #(
    parameter int DIGITS   = 2,
    parameter int SWAP_CYC = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    input  logic                clear,
    input  logic                stop,
    input  logic                pill,
    input  logic                bot_ready,
    input  logic [4*DIGITS-1:0] pill_max,
    input  logic [4*DIGITS-1:0] bot_max,
    output logic [4*DIGITS-1:0] pill_cnt,
    output logic [4*DIGITS-1:0] bot_cnt,
    output logic                gate_open,
    output logic                bot_req,
    output logic                busy,
    output logic                all_full,
    output logic                err
);
    localparam int W  = 4 * DIGITS;
    localparam int SW = (SWAP_CYC > 1) ? $clog2(SWAP_CYC) : 1;
    localparam logic [SW-1:0] SWAP_LAST = SW'(SWAP_CYC - 1);

    typedef enum logic [2:0] {IDLE, WAIT_BOT, FILL, SWAP, DONE} state_t;

    state_t        state_reg, state_next;
    logic [W-1:0]  pill_cnt_reg, pill_cnt_next;
    logic [W-1:0]  bot_cnt_reg, bot_cnt_next;
    logic [W-1:0]  pill_max_reg, pill_max_next;
    logic [W-1:0]  bot_max_reg, bot_max_next;
    logic [SW-1:0] swap_cnt_reg, swap_cnt_next;
    logic          gate_open_reg, gate_open_next;
    logic          bot_req_reg, bot_req_next;
    logic          busy_reg, busy_next;
    logic          all_full_reg, all_full_next;
    logic          err_reg, err_next;

    logic [W-1:0]      pill_inc, bot_inc;
    logic [DIGITS-1:0] pill_carry, bot_carry;
    logic [DIGITS-1:0] pill_dig_ok, bot_dig_ok;

    // Per-digit BCD increment with ripple carry, plus per-digit config range check.
    assign pill_carry[0] = 1'b1;
    assign bot_carry[0]  = 1'b1;
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] p_d, b_d;
            assign p_d = pill_cnt_reg[4*gi +: 4];
            assign b_d = bot_cnt_reg[4*gi +: 4];
            assign pill_inc[4*gi +: 4] = pill_carry[gi] ? ((p_d == 4'd9) ? 4'd0 : p_d + 4'd1) : p_d;
            assign bot_inc[4*gi +: 4]  = bot_carry[gi] ? ((b_d == 4'd9) ? 4'd0 : b_d + 4'd1) : b_d;
            assign pill_dig_ok[gi] = (pill_max[4*gi +: 4] <= 4'd9);
            assign bot_dig_ok[gi]  = (bot_max[4*gi +: 4] <= 4'd9);
            if (gi < DIGITS - 1) begin : g_carry
                assign pill_carry[gi+1] = pill_carry[gi] && (p_d == 4'd9);
                assign bot_carry[gi+1]  = bot_carry[gi] && (b_d == 4'd9);
            end
        end
    endgenerate

    logic cfg_ok, fill_count, bottle_done, batch_done, swap_done;
    assign cfg_ok      = (&pill_dig_ok) && (&bot_dig_ok) && (|pill_max) && (|bot_max);
    // A pill counts only while the gate is actually open and the line is not paused.
    assign fill_count  = (state_reg == FILL) && pill && gate_open_reg && !stop;
    assign bottle_done = fill_count && (pill_inc == pill_max_reg);
    assign batch_done  = bottle_done && (bot_inc == bot_max_reg);
    assign swap_done   = (state_reg == SWAP) && !stop && (swap_cnt_reg == SWAP_LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg     <= IDLE;
            pill_cnt_reg  <= '0;
            bot_cnt_reg   <= '0;
            pill_max_reg  <= '0;
            bot_max_reg   <= '0;
            swap_cnt_reg  <= '0;
            gate_open_reg <= 1'b0;
            bot_req_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            all_full_reg  <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pill_cnt_reg  <= pill_cnt_next;
            bot_cnt_reg   <= bot_cnt_next;
            pill_max_reg  <= pill_max_next;
            bot_max_reg   <= bot_max_next;
            swap_cnt_reg  <= swap_cnt_next;
            gate_open_reg <= gate_open_next;
            bot_req_reg   <= bot_req_next;
            busy_reg      <= busy_next;
            all_full_reg  <= all_full_next;
            err_reg       <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (clear) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:     if (start && cfg_ok) state_next = WAIT_BOT;
                WAIT_BOT: if (!stop && bot_ready) state_next = FILL;
                FILL:     if (bottle_done) state_next = batch_done ? DONE : SWAP;
                SWAP:     if (swap_done) state_next = WAIT_BOT;
                default:  state_next = state_reg;
            endcase
        end
    end

    always_comb begin
        pill_cnt_next  = pill_cnt_reg;
        bot_cnt_next   = bot_cnt_reg;
        pill_max_next  = pill_max_reg;
        bot_max_next   = bot_max_reg;
        swap_cnt_next  = swap_cnt_reg;
        gate_open_next = gate_open_reg;
        bot_req_next   = bot_req_reg;
        busy_next      = (state_next == WAIT_BOT) || (state_next == FILL) || (state_next == SWAP);
        all_full_next  = (state_next == DONE);
        err_next       = err_reg;
        if (clear) begin
            pill_cnt_next  = '0;
            bot_cnt_next   = '0;
            swap_cnt_next  = '0;
            gate_open_next = 1'b0;
            bot_req_next   = 1'b0;
            err_next       = 1'b0;
        end else begin
            err_next = err_reg || (pill && !gate_open_reg) ||
                       ((state_reg == IDLE) && start && !cfg_ok);
            case (state_reg)
                IDLE: begin
                    if (start && cfg_ok) begin
                        pill_max_next = pill_max;
                        bot_max_next  = bot_max;
                        bot_req_next  = 1'b1;
                    end
                end
                WAIT_BOT: begin
                    if (stop) begin
                        bot_req_next = 1'b0;
                    end else if (bot_ready) begin
                        bot_req_next   = 1'b0;
                        gate_open_next = 1'b1;
                    end else begin
                        bot_req_next = 1'b1;
                    end
                end
                FILL: begin
                    if (stop) begin
                        gate_open_next = 1'b0;
                    end else if (bottle_done) begin
                        gate_open_next = 1'b0;
                        pill_cnt_next  = pill_inc;
                        bot_cnt_next   = bot_inc;
                        swap_cnt_next  = '0;
                    end else begin
                        gate_open_next = 1'b1;
                        if (fill_count) pill_cnt_next = pill_inc;
                    end
                end
                SWAP: begin
                    if (swap_done) begin
                        pill_cnt_next = '0;
                        bot_req_next  = 1'b1;
                        swap_cnt_next = '0;
                    end else if (!stop) begin
                        swap_cnt_next = swap_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    gate_open_next = 1'b0;
                    bot_req_next   = 1'b0;
                end
            endcase
        end
    end

    assign pill_cnt  = pill_cnt_reg;
    assign bot_cnt   = bot_cnt_reg;
    assign gate_open = gate_open_reg;
    assign bot_req   = bot_req_reg;
    assign busy      = busy_reg;
    assign all_full  = all_full_reg;
    assign err       = err_reg;
endmodule

// File: tb/tb_bottle_fill_ctrl.sv
// Directed bench for bottle_fill_ctrl: each scenario task drives its stimulus
// and compares outputs against hand-computed values one cycle at a time.
module tb_bottle_fill_ctrl;
    localparam int DIGITS   = 2;
    localparam int SWAP_CYC = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       start = 1'b0, clear = 1'b0, stop = 1'b0, pill = 1'b0, bot_ready = 1'b0;
    logic [7:0] pill_max = 8'h00, bot_max = 8'h00;
    logic [7:0] pill_cnt, bot_cnt;
    logic       gate_open, bot_req, busy, all_full, err;

    int pass_cnt  = 0;
    int check_cnt = 0;

    bottle_fill_ctrl #(.DIGITS(DIGITS), .SWAP_CYC(SWAP_CYC)) dut (
        .CLK(CLK), .RST(RST), .start(start), .clear(clear), .stop(stop), .pill(pill),
        .bot_ready(bot_ready), .pill_max(pill_max), .bot_max(bot_max),
        .pill_cnt(pill_cnt), .bot_cnt(bot_cnt), .gate_open(gate_open), .bot_req(bot_req),
        .busy(busy), .all_full(all_full), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic pulse_pill();
        pill = 1'b1;
        tick();
        pill = 1'b0;
    endtask

    task automatic begin_batch(input logic [7:0] pm, input logic [7:0] bm);
        pill_max = pm;
        bot_max  = bm;
        bot_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        check_cnt++; if (pill_cnt !== 8'h00) $display("FAIL reset_pill_cnt: got %h want 00", pill_cnt); else pass_cnt++;
        check_cnt++; if (bot_cnt !== 8'h00) $display("FAIL reset_bot_cnt: got %h want 00", bot_cnt); else pass_cnt++;
        check_cnt++; if ({gate_open, bot_req, busy, all_full, err} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000", {gate_open, bot_req, busy, all_full, err}); else pass_cnt++;
        #2 RST = 1'b0;
        tick();
        check_cnt++; if ({bot_req, busy} !== 2'b00) $display("FAIL reset_idle: got %b want 00", {bot_req, busy}); else pass_cnt++;
        $display("[%0t] test_reset done", $time);
    endtask

    task automatic test_batch();
        int n;
        do_clear();
        pill_max = 8'h12;
        bot_max  = 8'h03;
        bot_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_cnt++; if ({bot_req, busy} !== 2'b11) $display("FAIL batch_start_req: got %b want 11", {bot_req, busy}); else pass_cnt++;
        tick();
        check_cnt++; if ({gate_open, bot_req} !== 2'b10) $display("FAIL batch_gate_open: got %b want 10", {gate_open, bot_req}); else pass_cnt++;
        for (int b = 1; b <= 3; b++) begin
            check_cnt++; if (pill_cnt !== 8'h00) $display("FAIL batch_bottle_start: bottle %0d got %h want 00", b, pill_cnt); else pass_cnt++;
            for (int p = 1; p <= 12; p++) begin
                pulse_pill();
                if (p == 9) begin
                    check_cnt++; if (pill_cnt !== 8'h09) $display("FAIL batch_p9: got %h want 09", pill_cnt); else pass_cnt++;
                end
                if (p == 10) begin
                    check_cnt++; if (pill_cnt !== 8'h10) $display("FAIL batch_p10: got %h want 10", pill_cnt); else pass_cnt++;
                end
                if (p == 12) begin
                    check_cnt++; if (pill_cnt !== 8'h12) $display("FAIL batch_p12: got %h want 12", pill_cnt); else pass_cnt++;
                    check_cnt++; if (gate_open !== 1'b0) $display("FAIL batch_close: got %b want 0", gate_open); else pass_cnt++;
                    check_cnt++; if (bot_cnt !== 8'(b)) $display("FAIL batch_bot_cnt: got %h want %h", bot_cnt, 8'(b)); else pass_cnt++;
                end
                if (p < 12) tick();
            end
            $display("[%0t] batch bottle %0d filled bot_cnt=%h", $time, b, bot_cnt);
            if (b < 3) begin
                n = 0;
                while (gate_open !== 1'b1 && n < 20) begin
                    tick();
                    n++;
                end
                check_cnt++; if (n >= 20) $display("FAIL batch_reopen: gate still %b after %0d cycles", gate_open, n); else pass_cnt++;
            end
        end
        check_cnt++; if ({all_full, gate_open, err, busy} !== 4'b1000)
            $display("FAIL batch_done_flags: got %b want 1000", {all_full, gate_open, err, busy}); else pass_cnt++;
        check_cnt++; if (bot_cnt !== 8'h03) $display("FAIL batch_bot_final: got %h want 03", bot_cnt); else pass_cnt++;
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        check_cnt++; if ({all_full, bot_req, busy} !== 3'b100) $display("FAIL batch_start_ignored: got %b want 100", {all_full, bot_req, busy}); else pass_cnt++;
    endtask

    task automatic test_carry();
        do_clear();
        begin_batch(8'h99, 8'h01);
        for (int p = 1; p <= 99; p++) begin
            pulse_pill();
            if (p == 10) begin
                check_cnt++; if (pill_cnt !== 8'h10) $display("FAIL carry_p10: got %h want 10", pill_cnt); else pass_cnt++;
            end
            if (p == 90) begin
                check_cnt++; if (pill_cnt !== 8'h90) $display("FAIL carry_p90: got %h want 90", pill_cnt); else pass_cnt++;
            end
            tick();
        end
        check_cnt++; if (bot_cnt !== 8'h01) $display("FAIL carry_bot: got %h want 01", bot_cnt); else pass_cnt++;
        check_cnt++; if (pill_cnt !== 8'h99) $display("FAIL carry_pill_hold: got %h want 99", pill_cnt); else pass_cnt++;
        check_cnt++; if ({all_full, busy, err} !== 3'b100) $display("FAIL carry_done: got %b want 100", {all_full, busy, err}); else pass_cnt++;
        pulse_pill();
        check_cnt++; if ({err, pill_cnt} !== {1'b1, 8'h99}) $display("FAIL carry_overspill: got %b/%h want 1/99", err, pill_cnt); else pass_cnt++;
        $display("[%0t] carry batch done pill_cnt=%h bot_cnt=%h", $time, pill_cnt, bot_cnt);
    endtask

    task automatic test_invalid();
        logic req_seen;
        do_clear();
        pill_max = 8'h1A;
        bot_max  = 8'h03;
        start = 1'b1;
        req_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            req_seen = req_seen | bot_req;
        end
        start = 1'b0;
        check_cnt++; if ({err, busy} !== 2'b10) $display("FAIL invalid_digit: got %b want 10", {err, busy}); else pass_cnt++;
        check_cnt++; if (req_seen !== 1'b0) $display("FAIL invalid_digit_req: got %b want 0", req_seen); else pass_cnt++;
        do_clear();
        check_cnt++; if (err !== 1'b0) $display("FAIL invalid_clear_err: got %b want 0", err); else pass_cnt++;
        pill_max = 8'h12;
        bot_max  = 8'h00;
        start = 1'b1;
        req_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            req_seen = req_seen | bot_req;
        end
        start = 1'b0;
        check_cnt++; if ({err, busy, req_seen} !== 3'b100) $display("FAIL invalid_zero: got %b want 100", {err, busy, req_seen}); else pass_cnt++;
        $display("[%0t] invalid configs rejected err=%b", $time, err);
    endtask

    task automatic test_stop();
        do_clear();
        begin_batch(8'h12, 8'h02);
        for (int p = 1; p <= 7; p++) begin
            pulse_pill();
            tick();
        end
        check_cnt++; if ({pill_cnt, gate_open} !== {8'h07, 1'b1}) $display("FAIL stop_pre: got %h/%b want 07/1", pill_cnt, gate_open); else pass_cnt++;
        stop = 1'b1;
        for (int s = 1; s <= 5; s++) begin
            if (s == 3) pulse_pill(); else tick();
            check_cnt++; if (gate_open !== 1'b0) $display("FAIL stop_gate: cycle %0d got %b want 0", s, gate_open); else pass_cnt++;
        end
        check_cnt++; if ({err, pill_cnt, busy} !== {1'b1, 8'h07, 1'b1}) $display("FAIL stop_hold: got %b/%h/%b want 1/07/1", err, pill_cnt, busy); else pass_cnt++;
        stop = 1'b0;
        tick();
        check_cnt++; if (gate_open !== 1'b1) $display("FAIL stop_resume_gate: got %b want 1", gate_open); else pass_cnt++;
        pulse_pill();
        check_cnt++; if (pill_cnt !== 8'h08) $display("FAIL stop_resume_count: got %h want 08", pill_cnt); else pass_cnt++;
        $display("[%0t] stop pause done pill_cnt=%h", $time, pill_cnt);
    endtask

    task automatic test_swap_timing();
        do_clear();
        begin_batch(8'h02, 8'h02);
        pulse_pill();
        tick();
        pulse_pill();
        check_cnt++; if ({gate_open, pill_cnt, bot_cnt} !== {1'b0, 8'h02, 8'h01})
            $display("FAIL swap_edge: got %b/%h/%h want 0/02/01", gate_open, pill_cnt, bot_cnt); else pass_cnt++;
        for (int c = 1; c <= SWAP_CYC - 1; c++) begin
            if (c == 1) pulse_pill(); else tick();
            check_cnt++; if ({gate_open, bot_req, pill_cnt} !== {1'b0, 1'b0, 8'h02})
                $display("FAIL swap_hold: cycle %0d got %b/%b/%h want 0/0/02", c, gate_open, bot_req, pill_cnt); else pass_cnt++;
        end
        check_cnt++; if (err !== 1'b1) $display("FAIL swap_overspill: got %b want 1", err); else pass_cnt++;
        tick();
        check_cnt++; if ({pill_cnt, bot_req} !== {8'h00, 1'b1}) $display("FAIL swap_exit: got %h/%b want 00/1", pill_cnt, bot_req); else pass_cnt++;
        tick();
        check_cnt++; if ({gate_open, bot_req} !== 2'b10) $display("FAIL swap_refill: got %b want 10", {gate_open, bot_req}); else pass_cnt++;
        $display("[%0t] swap timing done", $time);
    endtask

    task automatic test_rst_async();
        do_clear();
        begin_batch(8'h12, 8'h03);
        for (int p = 1; p <= 3; p++) begin
            pulse_pill();
            tick();
        end
        #3 RST = 1'b1;
        #1;
        check_cnt++; if ({pill_cnt, bot_cnt} !== 16'h0000) $display("FAIL rst_counts: got %h/%h want 00/00", pill_cnt, bot_cnt); else pass_cnt++;
        check_cnt++; if ({gate_open, bot_req, busy, all_full, err} !== 5'b0)
            $display("FAIL rst_flags: got %b want 00000", {gate_open, bot_req, busy, all_full, err}); else pass_cnt++;
        #1 RST = 1'b0;
        tick();
        check_cnt++; if ({bot_req, busy} !== 2'b00) $display("FAIL rst_stays_idle: got %b want 00", {bot_req, busy}); else pass_cnt++;
        $display("[%0t] async reset mid-fill done", $time);
    endtask

    task automatic test_clear();
        do_clear();
        pill_max = 8'h12;
        bot_max  = 8'h03;
        bot_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        pulse_pill();
        bot_ready = 1'b1;
        tick();
        for (int p = 1; p <= 3; p++) begin
            pulse_pill();
            tick();
        end
        check_cnt++; if ({pill_cnt, gate_open, err} !== {8'h03, 1'b1, 1'b1}) $display("FAIL clear_pre: got %h/%b/%b want 03/1/1", pill_cnt, gate_open, err); else pass_cnt++;
        do_clear();
        check_cnt++; if ({pill_cnt, bot_cnt} !== 16'h0000) $display("FAIL clear_counts: got %h/%h want 00/00", pill_cnt, bot_cnt); else pass_cnt++;
        check_cnt++; if ({gate_open, bot_req, busy, all_full, err} !== 5'b0)
            $display("FAIL clear_flags: got %b want 00000", {gate_open, bot_req, busy, all_full, err}); else pass_cnt++;
        tick();
        check_cnt++; if ({bot_req, busy} !== 2'b00) $display("FAIL clear_no_restart: got %b want 00", {bot_req, busy}); else pass_cnt++;
        $display("[%0t] clear mid-fill done", $time);
    endtask

    initial begin
        test_reset();
        test_batch();
        test_carry();
        test_invalid();
        test_stop();
        test_swap_timing();
        test_rst_async();
        test_clear();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
